// File: rtl/vliw_pkg.sv
// ============================================================================
// Module      : vliw_pkg
// Description : Shared VLIW bundle definitions (op classes, slot layout,
//               bundle packing helper) for the packer and the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vliw_pkg;

    typedef enum logic [1:0] {
        OP_IXU  = 2'd0,
        OP_LSU  = 2'd1,
        OP_BR   = 2'd2,
        OP_RSVD = 2'd3
    } op_class_e;

    localparam int SLOT_W       = 32;
    localparam int BUNDLE_W     = 128;
    localparam int BUNDLE_BYTES = 16;

    localparam int IXU1_HI = 127;
    localparam int IXU1_LO = 96;
    localparam int IXU2_HI = 95;
    localparam int IXU2_LO = 64;
    localparam int LSU_HI  = 63;
    localparam int LSU_LO  = 32;
    localparam int BR_HI   = 31;
    localparam int BR_LO   = 0;

    // Staging slot indices (not bit positions; see pack_bundle for layout)
    localparam logic [1:0] C_SLOT_IXU1 = 2'd0;
    localparam logic [1:0] C_SLOT_IXU2 = 2'd1;
    localparam logic [1:0] C_SLOT_LSU  = 2'd2;
    localparam logic [1:0] C_SLOT_BR   = 2'd3;

    typedef logic [3:0][SLOT_W-1:0] slot_array_t;

    function automatic logic [BUNDLE_W-1:0] pack_bundle(input slot_array_t slots);
        logic [BUNDLE_W-1:0] b;
        b[IXU1_HI:IXU1_LO] = slots[C_SLOT_IXU1];
        b[IXU2_HI:IXU2_LO] = slots[C_SLOT_IXU2];
        b[LSU_HI:LSU_LO]   = slots[C_SLOT_LSU];
        b[BR_HI:BR_LO]     = slots[C_SLOT_BR];
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bundle_slot_alloc.sv
// ============================================================================
// Module      : bundle_slot_alloc
// Description : Combinational slot allocator: target slot, conflict and
//               "bundle full after placement" for one offered op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bundle_slot_alloc
    import vliw_pkg::*;
(
    input  op_class_e   i_op_class,
    input  logic [1:0]  i_ixu_cnt,
    input  logic        i_lsu_used,
    input  logic        i_br_used,
    output logic [1:0]  o_slot_idx,
    output logic        o_conflict,
    output logic        o_full_after
);

    logic [1:0] w_ixu_after;
    logic       w_lsu_after;
    logic       w_br_after;

    always_comb begin
        o_slot_idx  = C_SLOT_IXU1;
        o_conflict  = 1'b0;
        w_ixu_after = i_ixu_cnt;
        w_lsu_after = i_lsu_used;
        w_br_after  = i_br_used;
        case (i_op_class)
            OP_IXU: begin
                o_slot_idx = (i_ixu_cnt == 2'd0) ? C_SLOT_IXU1 : C_SLOT_IXU2;
                if (i_ixu_cnt == 2'd2) begin
                    o_conflict = 1'b1;
                end else begin
                    w_ixu_after = i_ixu_cnt + 2'd1;
                end
            end
            OP_LSU: begin
                o_slot_idx  = C_SLOT_LSU;
                o_conflict  = i_lsu_used;
                w_lsu_after = 1'b1;
            end
            OP_BR: begin
                o_slot_idx = C_SLOT_BR;
                o_conflict = i_br_used;
                w_br_after = 1'b1;
            end
            default: ;
        endcase
        o_full_after = (w_ixu_after == 2'd2) & w_lsu_after & w_br_after;
    end

endmodule

`default_nettype wire

// File: rtl/bundle_packer.sv
// ============================================================================
// Module      : bundle_packer
// Description : Packs class-tagged 32-bit ops into 128-bit VLIW bundles with
//               byte addresses. Optional skid output register enabled by
//               defining BUNDLE_PACKER_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bundle_packer
    import vliw_pkg::*;
#(
    parameter logic [SLOT_W-1:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [31:0]       BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [SLOT_W-1:0]   op_word,
    input  logic [1:0]          op_class,
    input  logic                op_last,
    input  logic                flush,
    output logic                bundle_valid,
    input  logic                bundle_ready,
    output logic [BUNDLE_W-1:0] bundle_data,
    output logic [31:0]         bundle_addr,
    output logic                busy,
    output logic                err_class
);

    localparam logic [0:0]  C_FILL      = 1'b0;
    localparam logic [0:0]  C_EMIT      = 1'b1;
    localparam logic [31:0] C_ADDR_STEP = 32'(BUNDLE_BYTES);
    localparam slot_array_t C_NOP_SLOTS = {4{NOP_WORD}};

    logic [0:0]  r_state;
    slot_array_t r_slots;
    logic [1:0]  r_ixu_cnt;
    logic        r_lsu_used;
    logic        r_br_used;
    logic [31:0] r_addr;
    logic        r_err_class;

    op_class_e   w_class;
    logic [1:0]  w_slot_idx;
    logic        w_alloc_conflict;
    logic        w_full_after;
    logic        w_conflict;
    logic        w_accept;
    logic        w_accept_slot;
    logic        w_stage_busy;
    logic        w_nonempty_nxt;
    logic        w_close;
    slot_array_t w_slots_nxt;
    logic [1:0]  w_ixu_cnt_nxt;
    logic        w_lsu_nxt;
    logic        w_br_nxt;

    assign w_class = op_class_e'(op_class);

    bundle_slot_alloc u_slot_alloc (
        .i_op_class   (w_class),
        .i_ixu_cnt    (r_ixu_cnt),
        .i_lsu_used   (r_lsu_used),
        .i_br_used    (r_br_used),
        .o_slot_idx   (w_slot_idx),
        .o_conflict   (w_alloc_conflict),
        .o_full_after (w_full_after)
    );

    assign w_conflict    = op_valid & w_alloc_conflict & (r_state == C_FILL);
    assign op_ready      = rst_n & (r_state == C_FILL) & ~w_conflict;
    assign w_accept      = op_valid & op_ready;
    assign w_accept_slot = w_accept & (w_class != OP_RSVD);

    always_comb begin
        w_slots_nxt   = r_slots;
        w_ixu_cnt_nxt = r_ixu_cnt;
        w_lsu_nxt     = r_lsu_used;
        w_br_nxt      = r_br_used;
        if (w_accept_slot) begin
            w_slots_nxt[w_slot_idx] = op_word;
            case (w_class)
                OP_IXU:  w_ixu_cnt_nxt = r_ixu_cnt + 2'd1;
                OP_LSU:  w_lsu_nxt     = 1'b1;
                OP_BR:   w_br_nxt      = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_stage_busy   = (r_ixu_cnt != 2'd0) | r_lsu_used | r_br_used;
    assign w_nonempty_nxt = (w_ixu_cnt_nxt != 2'd0) | w_lsu_nxt | w_br_nxt;

    // Every close reason is qualified by post-accept occupancy so an empty
    // bundle (e.g. flush alongside a reserved op) is never produced.
    assign w_close = (r_state == C_FILL) & w_nonempty_nxt &
                     ((w_accept & (op_last | (w_class == OP_BR) | w_full_after)) |
                      w_conflict | flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_class <= 1'b0;
        end else if (w_accept && (w_class == OP_RSVD)) begin
            r_err_class <= 1'b1;
        end
    end

    assign err_class = r_err_class;

`ifdef BUNDLE_PACKER_SKID_EN

    logic                r_out_valid;
    logic [BUNDLE_W-1:0] r_out_data;
    logic [31:0]         r_out_addr;
    logic                w_out_free;

    assign w_out_free = ~r_out_valid | bundle_ready;

    // r_addr is the address the next bundle will take when it enters the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= C_FILL;
            r_slots     <= C_NOP_SLOTS;
            r_ixu_cnt   <= 2'd0;
            r_lsu_used  <= 1'b0;
            r_br_used   <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_out_valid <= 1'b0;
            r_out_data  <= pack_bundle(C_NOP_SLOTS);
            r_out_addr  <= BASE_ADDR;
        end else begin
            if (r_out_valid && bundle_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_state == C_FILL) begin
                if (w_close && w_out_free) begin
                    r_out_data  <= pack_bundle(w_slots_nxt);
                    r_out_addr  <= r_addr;
                    r_out_valid <= 1'b1;
                    r_addr      <= r_addr + C_ADDR_STEP;
                    r_slots     <= C_NOP_SLOTS;
                    r_ixu_cnt   <= 2'd0;
                    r_lsu_used  <= 1'b0;
                    r_br_used   <= 1'b0;
                end else begin
                    r_slots    <= w_slots_nxt;
                    r_ixu_cnt  <= w_ixu_cnt_nxt;
                    r_lsu_used <= w_lsu_nxt;
                    r_br_used  <= w_br_nxt;
                    if (w_close) begin
                        r_state <= C_EMIT;
                    end
                end
            end else if (w_out_free) begin
                r_out_data  <= pack_bundle(r_slots);
                r_out_addr  <= r_addr;
                r_out_valid <= 1'b1;
                r_addr      <= r_addr + C_ADDR_STEP;
                r_slots     <= C_NOP_SLOTS;
                r_ixu_cnt   <= 2'd0;
                r_lsu_used  <= 1'b0;
                r_br_used   <= 1'b0;
                r_state     <= C_FILL;
            end
        end
    end

    assign bundle_valid = r_out_valid;
    assign bundle_data  = r_out_data;
    assign bundle_addr  = r_out_addr;
    assign busy         = w_stage_busy | r_out_valid;

`else

    logic r_bundle_valid;

    // Staging doubles as the output register; it is frozen while in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= C_FILL;
            r_slots        <= C_NOP_SLOTS;
            r_ixu_cnt      <= 2'd0;
            r_lsu_used     <= 1'b0;
            r_br_used      <= 1'b0;
            r_addr         <= BASE_ADDR;
            r_bundle_valid <= 1'b0;
        end else if (r_state == C_FILL) begin
            r_slots    <= w_slots_nxt;
            r_ixu_cnt  <= w_ixu_cnt_nxt;
            r_lsu_used <= w_lsu_nxt;
            r_br_used  <= w_br_nxt;
            if (w_close) begin
                r_state        <= C_EMIT;
                r_bundle_valid <= 1'b1;
            end
        end else if (bundle_ready) begin
            r_slots        <= C_NOP_SLOTS;
            r_ixu_cnt      <= 2'd0;
            r_lsu_used     <= 1'b0;
            r_br_used      <= 1'b0;
            r_addr         <= r_addr + C_ADDR_STEP;
            r_bundle_valid <= 1'b0;
            r_state        <= C_FILL;
        end
    end

    assign bundle_valid = r_bundle_valid;
    assign bundle_data  = pack_bundle(r_slots);
    assign bundle_addr  = r_addr;
    assign busy         = w_stage_busy | r_bundle_valid;

`endif

endmodule

`default_nettype wire

// File: doc/bundle_packer.md
# bundle_packer

Packs a stream of 32-bit class-tagged operations into 128-bit VLIW bundles for the instruction-memory loader. It is the producer side of the instruction-fetch split: its bundle layout is ixu1 [127:96], ixu2 [95:64], lsu [63:32], branch [31:0]. Each completed bundle is emitted with its byte address through a valid/ready interface, and empty slots are filled with NOP.

## Interface
- NOP_WORD, default 32'h0000_0000: fill value for unoccupied slots.
- BASE_ADDR, default 32'h0000_0000: byte address of the first emitted bundle.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  offered op is valid.
- op_ready  output  1  packer accepts op this cycle.
- op_word  input  32  operation encoding.
- op_class  input  2  0 IXU, 1 LSU, 2 BR, 3 reserved.
- op_last  input  1  close the bundle after this op.
- flush  input  1  close the partial bundle.
- bundle_valid  output  1  bundle_data/bundle_addr valid.
- bundle_ready  input  1  consumer accepts bundle.
- bundle_data  output  128  packed bundle.
- bundle_addr  output  32  byte address of bundle_data.
- busy  output  1  staging non-empty or bundle_valid high.
- err_class  output  1  sticky: a reserved-class op was accepted.

## Operation
- Staging state: ixu_cnt (0..2), lsu_used, br_used, four 32-bit slot registers.
- FSM states:
  - FILL: op_ready = !conflict.
  - EMIT: op_ready = 0, bundle_valid = 1.
- Conflict means op_valid is high and the op's slot is taken: IXU with ixu_cnt==2, LSU with lsu_used, or BR with br_used.
- Placement on accept:
  - IXU goes to ixu1 if ixu_cnt==0, otherwise ixu2.
  - LSU goes to the lsu slot.
  - BR goes to the branch slot.
  - Reserved class is consumed and discarded, and sets err_class.
- FILL→EMIT triggers:
  - An accepted op with op_last or class BR.
  - A conflict: the op is not consumed, stays pending, and lands in the next bundle.
  - flush with staging non-empty.
  - Staging full (ixu_cnt==2, lsu_used, br_used) after an accept.
- flush behaviour:
  - flush with empty staging and no accept is ignored.
  - flush together with an accept includes the op, then closes.
  - An empty bundle is never emitted.
- EMIT→FILL on bundle_valid & bundle_ready: slots reset to NOP_WORD, occupancy cleared, bundle_addr += 16 (wraps modulo 2^32).
- op_ready depends on op_valid/op_class combinationally; op_valid must not depend on op_ready.
- Reset values:
  - State FILL, all slots NOP_WORD, bundle_addr BASE_ADDR.
  - bundle_valid 0, err_class 0, busy 0.
  - op_ready 0 while rst_n is low.
- Reset asserted mid-EMIT drops the bundle without a handshake.

## Timing
- Accept on op_valid & op_ready at a rising edge. The slot is written at that edge.
- bundle_valid rises on the edge that closes the bundle, so it is visible the cycle after the closing accept, flush or conflict.
- bundle_data/bundle_addr are held stable while bundle_valid & !bundle_ready.
- Base build: one FILL-blocked cycle per bundle minimum. Peak rate is 1 bundle per 2 cycles with single-op bundles.

## Configuration
- BUNDLE_PACKER_SKID_EN defined:
  - A separate output register is added.
  - A closing bundle moves staging into the output register when that register is empty or being handshaked in the same cycle.
  - FILL continues while the output is stalled.
  - op_ready also drops when staging wants to close and the output register is occupied and not draining.
  - Back-to-back single-op bundles sustain 1 bundle/cycle.
- Undefined: single-buffer behaviour as above.

## Structure
- vliw_pkg holds:
  - op_class_e enum.
  - SLOT_W=32, BUNDLE_W=128, BUNDLE_BYTES=16.
  - Slot bit-range localparams IXU1_HI/LO, IXU2_HI/LO, LSU_HI/LO, BR_HI/LO.
- The fetch stage shares vliw_pkg.
- Sub-module bundle_slot_alloc: combinational. Takes op_class and occupancy, and outputs target slot index, conflict and full_after.

## Test plan
- IXU A, IXU B, LSU C, BR D with bundle_ready=1 -> one bundle {A,B,C,D} at bundle_addr 0x0, then the next bundle at 0x10.
- IXU 0x11 with op_last -> {0x11,NOP,NOP,NOP}. IXU ops 1,2,3 -> {1,2,NOP,NOP}; op 3 held (op_ready=0 that cycle) and appears in ixu1 of the next bundle.
- Hold bundle_ready=0 for 5 cycles -> data and address stable, op_ready=0 (base build). SKID_EN build: a second bundle fills and stalls.
- flush with empty staging -> no bundle. flush with an accepted LSU 0x22 the same cycle -> {NOP,NOP,0x22,NOP}.
- op_class=3 -> op consumed, err_class=1 and stays 1 until reset. Reset during EMIT -> bundle_valid=0, bundle_addr=BASE_ADDR.
- BASE_ADDR=32'hFFFF_FFF0 with two bundles -> addresses 0xFFFF_FFF0 then 0x0000_0000.
